// File: rtl/mlp_seq.sv
// mlp_seq: sequential N-layer fully-connected network on one shared MAC.
// The input vector is streamed into ping-pong activation buffer A. Each layer
// then reads weights and biases from external single-port memories (1-cycle
// read latency), runs one neuron at a time (BIAS, in_dim MAC cycles, WB) and
// writes into the opposite buffer. The final vector is streamed out with
// valid/ready, and the argmax class is reported.
// Optional build macro: MLP_SEQ_ROUND_EN selects round-half-up in write-back
// instead of truncation toward -inf. Latency is the same in both builds.
module mlp_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_LAYERS  = 3,
  parameter int MAX_DIM     = 512,
  parameter int DIM_W       = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int WADDR_WIDTH = 24,
  parameter int BADDR_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [(NUM_LAYERS+1)*DIM_W-1:0] layer_dims,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  output logic                            w_rden,
  output logic [WADDR_WIDTH-1:0]          w_rdaddr,
  input  logic [DATA_WIDTH-1:0]           w_q,
  output logic                            b_rden,
  output logic [BADDR_WIDTH-1:0]          b_rdaddr,
  input  logic [DATA_WIDTH-1:0]           b_q,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [DIM_W-1:0]                out_index,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [DIM_W-1:0]                class_idx,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);

  localparam int AW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int LW = $clog2(NUM_LAYERS + 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CHECK = 4'd1;
  localparam logic [3:0] S_LOAD  = 4'd2;
  localparam logic [3:0] S_BIAS  = 4'd3;
  localparam logic [3:0] S_MAC   = 4'd4;
  localparam logic [3:0] S_WB    = 4'd5;
  localparam logic [3:0] S_NEXTL = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  // Saturation bounds of a DATA_WIDTH signed value, expressed at ACC_WIDTH.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

`ifdef MLP_SEQ_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] ROUND_INC = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);
`else
  localparam logic signed [ACC_WIDTH-1:0] ROUND_INC = '0;
`endif

  // Control state
  logic [3:0]             state;
  logic [DIM_W-1:0]       dims_q [NUM_LAYERS+1];
  logic [LW-1:0]          layer;
  logic [DIM_W-1:0]       n_cnt;
  logic [DIM_W-1:0]       k_cnt;
  logic [DIM_W-1:0]       load_cnt;
  logic                   src_sel;   // 0: A is source, B is destination
  logic [WADDR_WIDTH-1:0] w_base;
  logic [WADDR_WIDTH-1:0] w_row;     // n*in_dim, built by repeated addition
  logic [BADDR_WIDTH-1:0] b_base;

  // Datapath state
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0] act_q;
  logic signed [DATA_WIDTH-1:0] max_val;

  // Activation buffers
  logic [DATA_WIDTH-1:0] buf_a [MAX_DIM];
  logic [DATA_WIDTH-1:0] buf_b [MAX_DIM];

  // Derived combinational signals
  logic [LW-1:0]                layer_nxt;
  logic [DIM_W-1:0]             in_dim;
  logic [DIM_W-1:0]             out_dim;
  logic [DIM_W-1:0]             fin_dim;
  logic [DIM_W-1:0]             k_nxt;
  logic                         is_last;
  logic                         mac_more;
  logic                         cfg_bad;
  logic                         rd_bank;
  logic [AW-1:0]                rd_idx;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_bias;
  logic signed [ACC_WIDTH-1:0]  acc_nxt;
  logic signed [ACC_WIDTH-1:0]  acc_rnd;
  logic signed [ACC_WIDTH-1:0]  acc_shr;
  logic signed [DATA_WIDTH-1:0] wb_res;

  assign layer_nxt = layer + LW'(1);
  assign in_dim    = dims_q[layer];
  assign out_dim   = dims_q[layer_nxt];
  assign fin_dim   = dims_q[NUM_LAYERS];
  assign k_nxt     = k_cnt + DIM_W'(1);
  assign is_last   = (layer == LAST_LAYER);
  assign mac_more  = (k_nxt < in_dim);

  // Status outputs are pure decodes of the state register.
  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  // Memory reads: the bias and the first weight of a neuron are issued in
  // BIAS, the remaining weights one per MAC cycle ahead of their use.
  assign b_rden   = (state == S_BIAS);
  assign b_rdaddr = b_rden ? (b_base + BADDR_WIDTH'(n_cnt)) : '0;
  assign w_rden   = (state == S_BIAS) || ((state == S_MAC) && mac_more);
  assign w_rdaddr = w_rden ? (w_base + w_row + ((state == S_MAC) ? WADDR_WIDTH'(k_nxt) : '0)) : '0;

  // Any zero or oversized dimension field makes the configuration illegal.
  always_comb begin
    cfg_bad = 1'b0;
    for (int i = 0; i <= NUM_LAYERS; i++) begin
      if ((dims_q[i] == '0) || (32'(dims_q[i]) > MAX_DIM)) cfg_bad = 1'b1;
    end
  end

  // Shared buffer read port: source prefetch for MAC, result prefetch for DRAIN.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    rd_bank = src_sel;
    rd_idx  = '0;
    case (state)
      S_MAC:   rd_idx  = AW'(k_nxt);
      S_NEXTL: rd_bank = ~src_sel;
      S_DRAIN: rd_idx  = AW'(out_index + DIM_W'(1));
      default: ;
    endcase
  end

  assign rd_data = rd_bank ? buf_b[rd_idx] : buf_a[rd_idx];

  // MAC and write-back arithmetic.
  assign prod     = $signed(w_q) * act_q;
  assign acc_bias = ACC_WIDTH'($signed(b_q)) <<< FRAC_BITS;
  assign acc_nxt  = ((k_cnt == '0) ? acc_bias : acc) + ACC_WIDTH'(prod);
  assign acc_rnd  = acc + ROUND_INC;
  assign acc_shr  = acc_rnd >>> FRAC_BITS;

  // Saturate to the data range, then ReLU on every layer but the last.
  always_comb begin
    if (acc_shr > SAT_MAX)      wb_res = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc_shr < SAT_MIN) wb_res = SAT_MIN[DATA_WIDTH-1:0];
    else                        wb_res = acc_shr[DATA_WIDTH-1:0];
    if (!is_last && wb_res[DATA_WIDTH-1]) wb_res = '0;
  end

  // Activation buffer writes: input stream into A, neuron results into the destination.
  // NOTE: the buffers have no reset; their contents are don't-care after reset
  // and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && in_valid)  buf_a[AW'(load_cnt)] <= in_data;
    if ((state == S_WB) && src_sel)     buf_a[AW'(n_cnt)]    <= wb_res;
    if ((state == S_WB) && !src_sel)    buf_b[AW'(n_cnt)]    <= wb_res;
  end

  // Sequencer: FSM, counters, address bases, accumulator, argmax and output stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is always updated with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order.
      state     <= S_IDLE;
      for (int i = 0; i <= NUM_LAYERS; i++) dims_q[i] <= '0;
      layer     <= '0;
      n_cnt     <= '0;
      k_cnt     <= '0;
      load_cnt  <= '0;
      src_sel   <= 1'b0;
      w_base    <= '0;
      w_row     <= '0;
      b_base    <= '0;
      acc       <= '0;
      act_q     <= '0;
      max_val   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      class_idx <= '0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i <= NUM_LAYERS; i++) dims_q[i] <= layer_dims[i*DIM_W +: DIM_W];
            cfg_err   <= 1'b0;
            class_idx <= '0;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          load_cnt <= '0;
          layer    <= '0;
          n_cnt    <= '0;
          k_cnt    <= '0;
          src_sel  <= 1'b0;
          w_base   <= '0;
          w_row    <= '0;
          b_base   <= '0;
          max_val  <= '0;
          if (cfg_bad) begin
            cfg_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (load_cnt == dims_q[0] - DIM_W'(1)) state <= S_BIAS;
            else                                   load_cnt <= load_cnt + DIM_W'(1);
          end
        end
        S_BIAS: begin
          act_q <= rd_data;
          k_cnt <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (mac_more) begin
            act_q <= rd_data;
            k_cnt <= k_nxt;
          end else begin
            state <= S_WB;
          end
        end
        S_WB: begin
          w_row <= w_row + WADDR_WIDTH'(in_dim);
          if (is_last && ((n_cnt == '0) || (wb_res > max_val))) begin
            max_val   <= wb_res;
            class_idx <= n_cnt;
          end
          if (n_cnt == out_dim - DIM_W'(1)) begin
            state <= S_NEXTL;
          end else begin
            n_cnt <= n_cnt + DIM_W'(1);
            state <= S_BIAS;
          end
        end
        S_NEXTL: begin
          w_base  <= w_base + w_row;
          w_row   <= '0;
          b_base  <= b_base + BADDR_WIDTH'(out_dim);
          n_cnt   <= '0;
          src_sel <= ~src_sel;
          if (is_last) begin
            // Prefetch element 0 of the final buffer so DRAIN starts valid.
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_index <= '0;
            out_last  <= (fin_dim == DIM_W'(1));
            state     <= S_DRAIN;
          end else begin
            layer <= layer_nxt;
            state <= S_BIAS;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              out_index <= '0;
              state     <= S_DONE;
            end else begin
              out_data  <= rd_data;
              out_index <= out_index + DIM_W'(1);
              out_last  <= ((out_index + DIM_W'(2)) == fin_dim);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq.sv
// Testbench for mlp_seq: two-layer build with MAX_DIM=8. Expected final
// vectors come from hand-derived constants or a plain-arithmetic network model;
// a monitor pops the scoreboard on every accepted output beat.
module tb_mlp_seq;

  localparam int DW    = 16;
  localparam int NL    = 2;
  localparam int MAXD  = 8;
  localparam int DIM_W = 16;
  localparam int WAW   = 24;
  localparam int BAW   = 12;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [(NL+1)*DIM_W-1:0]  layer_dims;
  logic                     in_valid;
  logic [DW-1:0]            in_data;
  logic                     in_ready;
  logic                     w_rden;
  logic [WAW-1:0]           w_rdaddr;
  logic [DW-1:0]            w_q;
  logic                     b_rden;
  logic [BAW-1:0]           b_rdaddr;
  logic [DW-1:0]            b_q;
  logic                     out_valid;
  logic [DW-1:0]            out_data;
  logic [DIM_W-1:0]         out_index;
  logic                     out_last;
  logic                     out_ready;
  logic [DIM_W-1:0]         class_idx;
  logic                     busy;
  logic                     done;
  logic                     cfg_err;

  mlp_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_LAYERS(NL), .MAX_DIM(MAXD),
    .DIM_W(DIM_W), .ACC_WIDTH(40), .WADDR_WIDTH(WAW), .BADDR_WIDTH(BAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_dims(layer_dims),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_rden(w_rden), .w_rdaddr(w_rdaddr), .w_q(w_q),
    .b_rden(b_rden), .b_rdaddr(b_rdaddr), .b_q(b_q),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .out_ready(out_ready), .class_idx(class_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // External weight/bias memories with one-cycle read latency.
  logic [DW-1:0] wmem [256];
  logic [DW-1:0] bmem [64];
  initial begin
    w_q = '0;
    b_q = '0;
  end
  always @(posedge clk) begin
    if (w_rden) w_q <= wmem[w_rdaddr[7:0]];
    if (b_rden) b_q <= bmem[b_rdaddr[5:0]];
  end

  int cyc = 0;
  int rd_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (w_rden || b_rden) rd_cnt <= rd_cnt + 1;

  // Scoreboard
  typedef struct {
    logic [DW-1:0]    data;
    logic [DIM_W-1:0] idx;
    logic             last;
  } beat_t;
  beat_t exp_q[$];

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data",  out_data,  e.data);
        check("out_index", out_index, e.idx);
        check("out_last",  out_last,  e.last);
      end
    end
  end

  // Sink: always ready, or toggling 1010... under backpressure.
  bit bp_mode  = 0;
  bit gap_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? ~out_ready : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "time limit reached");
  end

  // Reference network: per neuron, bias<<FRAC + sum of weight*activation,
  // then floor shift (optionally rounded), saturation and hidden-layer ReLU.
  function automatic void model(input int d[3], input int x[$], output int y[$], output int cls);
    int a[$];
    int nx[$];
    int wb;
    int bb;
    longint acc;
    longint r;
    a  = x;
    wb = 0;
    bb = 0;
    for (int l = 0; l < NL; l++) begin
      nx.delete();
      for (int n = 0; n < d[l+1]; n++) begin
        acc = longint'($signed(bmem[bb+n])) * 256;
        for (int k = 0; k < d[l]; k++)
          acc += longint'($signed(wmem[wb + n*d[l] + k])) * a[k];
`ifdef MLP_SEQ_ROUND_EN
        acc += 128;
`endif
        r = acc >>> 8;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if ((l < NL-1) && (r < 0)) r = 0;
        nx.push_back(int'(r));
      end
      wb += d[l] * d[l+1];
      bb += d[l+1];
      a = nx;
    end
    y   = a;
    cls = 0;
    for (int i = 1; i < y.size(); i++) if (y[i] > y[cls]) cls = i;
  endfunction

  int start_cyc;

  task automatic apply_start(input int d[3]);
    start      = 1'b1;
    layer_dims = {DIM_W'(d[2]), DIM_W'(d[1]), DIM_W'(d[0])};
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic drive_inputs(input int x[$]);
    int guard;
    for (int i = 0; i < x.size(); i++) begin
      if (gap_mode) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = x[i][DW-1:0];
      guard    = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
        guard++;
        @(negedge clk);
      end
      if (!in_ready) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // One complete run: queue expectations, start, feed, wait for done, check status.
  task automatic run_net(input int d[3], input int x[$], input int y[$], input int cls,
                         input int exp_lat, input bit illegal, input bit poke);
    int lat;
    int guard;
    int rd_base;
    beat_t b;
    rd_base = rd_cnt;
    if (!illegal) begin
      for (int i = 0; i < y.size(); i++) begin
        b.data = y[i][DW-1:0];
        b.idx  = DIM_W'(i);
        b.last = (i == y.size() - 1);
        exp_q.push_back(b);
      end
    end
    apply_start(d);
    if (!illegal) begin
      drive_inputs(x);
      if (poke) begin
        repeat (2) @(posedge clk);
        #1;
        start      = 1'b1;
        layer_dims = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    guard = 0;
    @(negedge clk);
    while (!done && guard < 3000) begin
      guard++;
      @(negedge clk);
    end
    lat = cyc - start_cyc;
    check("done_seen", {63'd0, done}, 64'd1);
    if (exp_lat >= 0) check("done_latency", lat, exp_lat);
    check("cfg_err", {63'd0, cfg_err}, {63'd0, illegal});
    if (illegal) begin
      check("no_mem_reads", rd_cnt - rd_base, 0);
    end else begin
      check("class_idx", class_idx, cls);
      check("beats_outstanding", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check("idle_after_done", {62'd0, busy, done}, 64'd0);
    check("cfg_err_held", {63'd0, cfg_err}, {63'd0, illegal});
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctl"}, {56'd0, busy, done, cfg_err, in_ready, out_valid, out_last, w_rden, b_rden}, 64'd0);
    check({tag, "_addr"}, {28'd0, w_rdaddr, b_rdaddr}, 64'd0);
    check({tag, "_out"}, {16'd0, class_idx, out_data, out_index}, 64'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) wmem[i] = '0;
    for (int i = 0; i < 64; i++)  bmem[i] = '0;
  endtask

  task automatic random_mem();
    for (int i = 0; i < 256; i++) wmem[i] = DW'($urandom_range(0, 1023)) - DW'(512);
    for (int i = 0; i < 64; i++)  bmem[i] = DW'($urandom_range(0, 1023)) - DW'(512);
  endtask

  int d[3];
  int xq[$];
  int yq[$];
  int cls;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    layer_dims = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    clear_mem();

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed two-layer network with a hand-derived result.
    wmem[0] = 16'h0100; wmem[1] = 16'h0000; wmem[2] = 16'h0000; wmem[3] = 16'hFF00;
    wmem[4] = 16'h0100; wmem[5] = 16'h0100; wmem[6] = 16'hFF00; wmem[7] = 16'h0200;
    bmem[0] = 16'h0000; bmem[1] = 16'h0000; bmem[2] = 16'h0000; bmem[3] = 16'h0080;
    xq = '{256, 512};
    yq = '{256, -128};
    run_net('{2, 2, 2}, xq, yq, 0, 23, 1'b0, 1'b0);

    // Saturation on the last layer, positive then negative.
    clear_mem();
    wmem[0] = 16'h0100; wmem[1] = 16'h7FFF;
    xq = '{32767};
    yq = '{32767};
    run_net('{1, 1, 1}, xq, yq, 0, 11, 1'b0, 1'b0);
    wmem[1] = 16'h8000;
    yq = '{-32768};
    run_net('{1, 1, 1}, xq, yq, 0, 11, 1'b0, 1'b0);

    // The same saturating product in a hidden layer is clamped to zero by ReLU.
    wmem[0] = 16'h8000; wmem[1] = 16'h0100;
    yq = '{0};
    run_net('{1, 1, 1}, xq, yq, 0, 11, 1'b0, 1'b0);

    // Final accumulator 0x180: 1.5 LSB truncates to 1, rounds to 2.
    wmem[0] = 16'h0100; wmem[1] = 16'h0001;
    xq = '{384};
`ifdef MLP_SEQ_ROUND_EN
    yq = '{2};
`else
    yq = '{1};
`endif
    run_net('{1, 1, 1}, xq, yq, 0, 11, 1'b0, 1'b0);

    // Ties: outputs {5,9,9} report the lower index.
    clear_mem();
    wmem[0] = 16'h0100;
    bmem[1] = 16'd5; bmem[2] = 16'd9; bmem[3] = 16'd9;
    xq = '{256};
    yq = '{5, 9, 9};
    run_net('{1, 1, 3}, xq, yq, 1, -1, 1'b0, 1'b0);

    // Illegal configurations, then a legal run clears cfg_err.
    xq.delete();
    yq.delete();
    run_net('{0, 4, 2}, xq, yq, 0, 1, 1'b1, 1'b0);
    run_net('{4, MAXD + 1, 2}, xq, yq, 0, 1, 1'b1, 1'b0);
    xq = '{256};
    yq = '{5, 9, 9};
    run_net('{1, 1, 3}, xq, yq, 1, -1, 1'b0, 1'b0);

    // Random networks with input gaps and output backpressure.
    for (int t = 0; t < 8; t++) begin
      gap_mode = 1'b1;
      bp_mode  = (t % 3 != 2);
      for (int i = 0; i < 3; i++) d[i] = (t == 2) ? $urandom_range(3, MAXD) : $urandom_range(1, MAXD);
      if (t == 7) d = '{MAXD, MAXD, MAXD};
      random_mem();
      xq.delete();
      for (int i = 0; i < d[0]; i++) xq.push_back(int'($urandom_range(0, 2047)) - 1024);
      model(d, xq, yq, cls);
      run_net(d, xq, yq, cls, -1, 1'b0, t == 2);
    end
    gap_mode = 1'b0;
    bp_mode  = 1'b0;

    // Asynchronous reset in the middle of a MAC sequence.
    d = '{4, 4, 2};
    random_mem();
    xq.delete();
    for (int i = 0; i < 4; i++) xq.push_back(int'($urandom_range(0, 2047)) - 1024);
    apply_start(d);
    drive_inputs(xq);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model(d, xq, yq, cls);
    run_net(d, xq, yq, cls, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
